// File: rtl/genie_pkg.sv
// Shared types and helpers for the genie interconnect blocks.
package genie_pkg;

    // Occupancy of the two-entry pipeline register.
    typedef enum logic [1:0] {
        PR_EMPTY = 2'd0,  // main and skid invalid
        PR_ONE   = 2'd1,  // main valid
        PR_TWO   = 2'd2   // main and skid valid
    } pipe_reg_state_t;

    // Port width that stays legal when a field is configured to zero bits.
    function automatic int unsigned safe_width(input int unsigned w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/genie_pipe_slot.sv
// One storage entry of the pipeline register: an enable-loaded word with no reset.
module genie_pipe_slot #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] word_q;

    // Capture the incoming word whenever the controller asks for it.
    // NOTE: datapath flops carry no reset; the valid bits in the controller decide whether the content means anything.
    always_ff @(posedge clk) begin
        if (load_i) begin
            word_q <= d_i;
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/genie_pipe_reg.sv
// Registered valid/ready stage (two-entry skid buffer) carrying {data, field}.
// Forward and backward paths are both cut: o_valid and o_ready decode flops only.
module genie_pipe_reg
    import genie_pkg::*;
#(
    parameter int unsigned WIDTH_DATA  = 0,
    parameter int unsigned WIDTH_FIELD = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [safe_width(WIDTH_DATA)-1:0]  i_data,
    input  logic [WIDTH_FIELD-1:0]             i_field,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [safe_width(WIDTH_DATA)-1:0]  o_data,
    output logic [WIDTH_FIELD-1:0]             o_field
);

    // Stored word layout: data (when present) above the field.
    localparam int unsigned SLOT_W = WIDTH_DATA + WIDTH_FIELD;

    pipe_reg_state_t state_q;
    logic            in_reset_q;

    logic            in_xfer;
    logic            out_xfer;
    logic            m_load;
    logic            s_load;
    logic [SLOT_W-1:0] slot_in;
    logic [SLOT_W-1:0] m_d;
    logic [SLOT_W-1:0] m_q;
    logic [SLOT_W-1:0] s_q;

    // Handshakes as seen at the coming clock edge.
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;

    // Port decode straight from flops so no input reaches an output combinationally.
    assign o_valid = (state_q != PR_EMPTY);
    assign o_ready = (state_q != PR_TWO) && !in_reset_q;

    // Occupancy FSM plus the flop that keeps o_ready low until the first edge after reset release.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PR_EMPTY;
            in_reset_q <= 1'b1;
        end else begin
            in_reset_q <= 1'b0;
            unique case (state_q)
                PR_EMPTY: begin
                    if (in_xfer) begin
                        state_q <= PR_ONE;
                    end
                end
                PR_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_q <= PR_TWO;
                    end else if (!in_xfer && out_xfer) begin
                        state_q <= PR_EMPTY;
                    end
                end
                PR_TWO: begin
                    // o_ready is low here, so only a drain can happen.
                    if (out_xfer) begin
                        state_q <= PR_ONE;
                    end
                end
                default: begin
                    state_q <= PR_EMPTY;
                end
            endcase
        end
    end

    // Slot load enables and the main-register source select.
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        m_load = 1'b0;
        s_load = 1'b0;
        m_d    = slot_in;
        unique case (state_q)
            PR_EMPTY: begin
                m_load = in_xfer;
            end
            PR_ONE: begin
                // Simultaneous in/out replaces main in place; in without out parks the beat in skid.
                m_load = in_xfer && out_xfer;
                s_load = in_xfer && !out_xfer;
            end
            PR_TWO: begin
                // Draining from TWO promotes the skid entry.
                m_load = out_xfer;
                m_d    = s_q;
            end
            default: begin
                m_load = 1'b0;
            end
        endcase
    end

    // Pack the incoming beat; with no data bits only the field is stored.
    if (WIDTH_DATA > 0) begin : g_data
        assign slot_in = {i_data, i_field};
        assign o_data  = m_q[SLOT_W-1:WIDTH_FIELD];
    end else begin : g_no_data
        logic unused_data;
        assign unused_data = ^i_data;
        assign slot_in     = i_field;
        assign o_data      = '0;
    end

    assign o_field = m_q[WIDTH_FIELD-1:0];

    // Main entry: drives the downstream outputs.
    genie_pipe_slot #(
        .WIDTH (SLOT_W)
    ) u_main (
        .clk    (clk),
        .load_i (m_load),
        .d_i    (m_d),
        .q_o    (m_q)
    );

    // Skid entry: absorbs the beat accepted while downstream stalls.
    genie_pipe_slot #(
        .WIDTH (SLOT_W)
    ) u_skid (
        .clk    (clk),
        .load_i (s_load),
        .d_i    (slot_in),
        .q_o    (s_q)
    );

    // A stalled beat must stay put until it is taken.
    a_stall_stable: assert property (
        @(posedge clk) disable iff (!reset)
        (o_valid && !i_ready) |=> (o_valid && $stable(o_data) && $stable(o_field))
    );

endmodule

// File: tb/tb_genie_pipe_reg.sv
// Directed bench for genie_pipe_reg: reset behaviour, streaming, stall/skid,
// randomised handshakes against a FIFO scoreboard, mid-flight reset, field-only build.
module tb_genie_pipe_reg;

    logic clk = 1'b0;
    logic reset;

    // Main instance: 8-bit data, 2-bit field.
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data;
    logic [1:0] i_field;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic [1:0] o_field;

    // Field-only instance: no data, 4-bit field.
    logic       z_i_valid;
    logic       z_o_ready;
    logic [0:0] z_i_data;
    logic [3:0] z_i_field;
    logic       z_o_valid;
    logic       z_i_ready;
    logic [0:0] z_o_data;
    logic [3:0] z_o_field;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam int NB_RAND = 10000;

    genie_pipe_reg #(
        .WIDTH_DATA  (8),
        .WIDTH_FIELD (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_field (i_field),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_field (o_field)
    );

    genie_pipe_reg #(
        .WIDTH_DATA  (0),
        .WIDTH_FIELD (4)
    ) dut_z (
        .clk     (clk),
        .reset   (reset),
        .i_valid (z_i_valid),
        .o_ready (z_o_ready),
        .i_data  (z_i_data),
        .i_field (z_i_field),
        .o_valid (z_o_valid),
        .i_ready (z_i_ready),
        .o_data  (z_o_data),
        .o_field (z_o_field)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_beat;
        logic [9:0] q[$];
        int         sent;
        int         rcvd;
        int         cyc;

        reset     = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        i_field   = '0;
        i_ready   = 1'b0;
        z_i_valid = 1'b0;
        z_i_data  = '0;
        z_i_field = '0;
        z_i_ready = 1'b1;

        // ---- 1: reset for three cycles, then release ----
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t1_rst_valid", o_valid, 0);
            check("t1_rst_ready", o_ready, 0);
        end
        reset = 1'b1;
        #1;
        check("t1_rel_ready_pre_edge", o_ready, 0);
        drive_slot();
        check("t1_rel_ready_post_edge", o_ready, 1);
        check("t1_rel_valid", o_valid, 0);

        // ---- 2: stream 8 beats with downstream always ready ----
        i_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive_slot();
            i_valid = (c < 8);
            i_data  = 8'(c);
            i_field = 2'h3;
            @(negedge clk);
            if (c == 0 || c == 9) begin
                check("t2_valid_idle", o_valid, 0);
            end else begin
                check("t2_valid", o_valid, 1);
                check("t2_data", o_data, 32'(c - 1));
                check("t2_field", o_field, 2'h3);
            end
            check("t2_ready", o_ready, 1);
        end

        // ---- 3: fill both entries under stall, then drain ----
        i_ready = 1'b0;
        drive_slot();
        i_valid = 1'b1;
        i_data  = 8'hA1;
        i_field = 2'h1;
        @(negedge clk);
        check("t3_ready_empty", o_ready, 1);
        drive_slot();
        i_data  = 8'hA2;
        i_field = 2'h2;
        @(negedge clk);
        check("t3_one_valid", o_valid, 1);
        check("t3_one_data", o_data, 8'hA1);
        check("t3_one_ready", o_ready, 1);
        for (int c = 0; c < 3; c++) begin
            drive_slot();
            i_valid = 1'b0;
            @(negedge clk);
            check("t3_two_ready", o_ready, 0);
            check("t3_two_valid", o_valid, 1);
            check("t3_two_data", o_data, 8'hA1);
            check("t3_two_field", o_field, 2'h1);
        end
        drive_slot();
        i_ready = 1'b1;
        @(negedge clk);
        check("t3_drain0_data", o_data, 8'hA1);
        drive_slot();
        @(negedge clk);
        check("t3_drain1_valid", o_valid, 1);
        check("t3_drain1_data", o_data, 8'hA2);
        check("t3_drain1_field", o_field, 2'h2);
        check("t3_drain1_ready", o_ready, 1);
        drive_slot();
        @(negedge clk);
        check("t3_drained", o_valid, 0);

        // ---- 4: random handshakes against a FIFO scoreboard ----
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < NB_RAND && cyc < 60000) begin
            drive_slot();
            i_valid = (sent < NB_RAND) && ($urandom_range(0, 1) == 1);
            i_data  = 8'(sent);
            i_field = 2'(sent >> 8) ^ 2'(sent);
            i_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (i_valid && o_ready) begin
                q.push_back({i_field, i_data});
                sent++;
            end
            if (o_valid && i_ready) begin
                check("t4_sb_nonempty", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_beat = q.pop_front();
                    check("t4_data", o_data, exp_beat[7:0]);
                    check("t4_field", o_field, exp_beat[9:8]);
                end
                rcvd++;
            end
            cyc++;
        end
        check("t4_received", rcvd, NB_RAND);
        check("t4_sb_left", q.size(), 0);

        // ---- 5: fill to TWO, reset asynchronously mid-cycle ----
        drive_slot();
        i_ready = 1'b0;
        i_valid = 1'b0;
        repeat (3) drive_slot();
        i_valid = 1'b1;
        i_data  = 8'hB1;
        i_field = 2'h1;
        drive_slot();
        i_data  = 8'hB2;
        drive_slot();
        i_valid = 1'b0;
        @(negedge clk);
        check("t5_full_ready", o_ready, 0);
        check("t5_full_valid", o_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_valid", o_valid, 0);
        check("t5_async_ready", o_ready, 0);
        @(negedge clk);
        i_ready = 1'b1;
        reset   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive_slot();
            @(negedge clk);
            check("t5_post_valid", o_valid, 0);
        end
        check("t5_post_ready", o_ready, 1);
        drive_slot();
        i_valid = 1'b1;
        i_data  = 8'hC5;
        i_field = 2'h2;
        @(negedge clk);
        check("t5_new_ready", o_ready, 1);
        drive_slot();
        i_valid = 1'b0;
        @(negedge clk);
        check("t5_new_valid", o_valid, 1);
        check("t5_new_data", o_data, 8'hC5);
        check("t5_new_field", o_field, 2'h2);
        drive_slot();
        @(negedge clk);
        check("t5_new_gone", o_valid, 0);

        // ---- 6: field-only instance streams 0x1..0xF ----
        z_i_ready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            drive_slot();
            z_i_valid = (c < 15);
            z_i_data  = 1'b1;
            z_i_field = 4'(c + 1);
            @(negedge clk);
            if (c == 0 || c == 16) begin
                check("t6_valid_idle", z_o_valid, 0);
            end else begin
                check("t6_valid", z_o_valid, 1);
                check("t6_field", z_o_field, 32'(c));
                check("t6_data_tied", z_o_data, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
